// File: rtl/contador_relogio.sv
// -----------------------------------------------------------------------------
// contador_relogio
// Real-time clock core: divides the system clock down to a 1 Hz tick and
// keeps hours:minutes:seconds. While an external adjust controller holds
// `pause`, time-keeping freezes and a display-blink square wave runs. A
// single-cycle `load` strobe writes a new time, clamping out-of-range fields.
//
// Parameters
//   DIV          system clock cycles per second (even, 4..2^27)
// Ports
//   clk_100MHz   system clock, all state on rising edge
//   rst          synchronous active-high reset
//   pause        hold time-keeping, enable blink generator
//   load         single-cycle strobe: copy *_in into the time registers
//   segundos_in  seconds to load (values >59 load as 59)
//   minutos_in   minutes to load (values >59 load as 59)
//   horas_in     hours to load   (values >23 load as 23)
//   segundos     current seconds 0..59
//   minutos      current minutes 0..59
//   horas        current hours   0..23
//   tick_1hz     one-cycle pulse per elapsed second
//   dia_pulse    one-cycle pulse on 23:59:59 -> 00:00:00
//   blink        square wave of period DIV while paused, else 0
// -----------------------------------------------------------------------------
module contador_relogio #(
    parameter int DIV = 100_000_000
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       pause,
    input  logic       load,
    input  logic [5:0] segundos_in,
    input  logic [5:0] minutos_in,
    input  logic [5:0] horas_in,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [5:0] horas,
    output logic       tick_1hz,
    output logic       dia_pulse,
    output logic       blink
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    logic [CW-1:0] presc_q, presc_d;
    logic [CW-1:0] bcnt_q,  bcnt_d;
    logic [5:0]    seg_q, seg_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    hor_q, hor_d;
    logic          tick_q, tick_d;
    logic          dia_q,  dia_d;
    logic          blink_q, blink_d;

    // Time-keeping: load has priority over pause, and pause over the tick.
    always_comb begin
        presc_d = presc_q;
        seg_d   = seg_q;
        min_d   = min_q;
        hor_d   = hor_q;
        tick_d  = 1'b0;
        dia_d   = 1'b0;

        if (load) begin
            presc_d = '0;
            seg_d   = (segundos_in > 6'd59) ? 6'd59 : segundos_in;
            min_d   = (minutos_in  > 6'd59) ? 6'd59 : minutos_in;
            hor_d   = (horas_in    > 6'd23) ? 6'd23 : horas_in;
        end else if (pause) begin
            presc_d = '0;
        end else if (presc_q == TERM) begin
            // Terminal count: the tick and the resulting time change appear
            // together on this edge; carries ripple through in one cycle.
            presc_d = '0;
            tick_d  = 1'b1;
            if (seg_q >= 6'd59) begin
                seg_d = 6'd0;
                if (min_q >= 6'd59) begin
                    min_d = 6'd0;
                    if (hor_q >= 6'd23) begin
                        hor_d = 6'd0;
                        dia_d = 1'b1;
                    end else begin
                        hor_d = hor_q + 6'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                seg_d = seg_q + 6'd1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Blink generator: the registered output reflects the count value held
    // before each edge, so the first paused cycle shows count 0 (blink high).
    always_comb begin
        bcnt_d  = '0;
        blink_d = 1'b0;
        if (pause) begin
            blink_d = (bcnt_q < HALF);
            bcnt_d  = (bcnt_q == TERM) ? '0 : bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            presc_q <= '0;
            bcnt_q  <= '0;
            seg_q   <= 6'd0;
            min_q   <= 6'd0;
            hor_q   <= 6'd0;
            tick_q  <= 1'b0;
            dia_q   <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            seg_q   <= seg_d;
            min_q   <= min_d;
            hor_q   <= hor_d;
            tick_q  <= tick_d;
            dia_q   <= dia_d;
            blink_q <= blink_d;
        end
    end

    assign segundos  = seg_q;
    assign minutos   = min_q;
    assign horas     = hor_q;
    assign tick_1hz  = tick_q;
    assign dia_pulse = dia_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_contador_relogio.sv
// -----------------------------------------------------------------------------
// tb_contador_relogio
// Directed bench for contador_relogio with DIV=10. The stimulus process pushes
// expected output snapshots tagged with the clock-edge number at which they
// must hold; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_contador_relogio;

    logic       clk_100MHz;
    logic       rst;
    logic       pause;
    logic       load;
    logic [5:0] segundos_in;
    logic [5:0] minutos_in;
    logic [5:0] horas_in;
    logic [5:0] segundos;
    logic [5:0] minutos;
    logic [5:0] horas;
    logic       tick_1hz;
    logic       dia_pulse;
    logic       blink;

    contador_relogio #(.DIV(10)) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .pause      (pause),
        .load       (load),
        .segundos_in(segundos_in),
        .minutos_in (minutos_in),
        .horas_in   (horas_in),
        .segundos   (segundos),
        .minutos    (minutos),
        .horas      (horas),
        .tick_1hz   (tick_1hz),
        .dia_pulse  (dia_pulse),
        .blink      (blink)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    typedef struct {
        string    name;
        int       cyc;
        int       s, m, h;
        bit       t, d, b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void ex(string name, int c, int s, int m, int h,
                               bit t, bit d, bit b);
        exp_t e;
        e.name = name; e.cyc = c;
        e.s = s; e.m = m; e.h = h;
        e.t = t; e.d = d; e.b = b;
        sb_q.push_back(e);
    endfunction

    // Monitor: compare every expectation due at the current edge count.
    always @(negedge clk_100MHz) begin
        int i;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].cyc == cyc) begin
                n_checks++;
                if (int'(segundos) == sb_q[i].s && int'(minutos) == sb_q[i].m &&
                    int'(horas) == sb_q[i].h && tick_1hz == sb_q[i].t &&
                    dia_pulse == sb_q[i].d && blink == sb_q[i].b) begin
                    n_pass++;
                    $display("check %s cyc=%0d ok %0d:%0d:%0d tick=%b dia=%b blink=%b",
                             sb_q[i].name, cyc, horas, minutos, segundos,
                             tick_1hz, dia_pulse, blink);
                end else begin
                    $display("FAIL %s cyc=%0d got %0d:%0d:%0d tick=%b dia=%b blink=%b want %0d:%0d:%0d tick=%b dia=%b blink=%b",
                             sb_q[i].name, cyc, horas, minutos, segundos,
                             tick_1hz, dia_pulse, blink,
                             sb_q[i].h, sb_q[i].m, sb_q[i].s,
                             sb_q[i].t, sb_q[i].d, sb_q[i].b);
                end
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    initial begin
        rst = 1'b1; pause = 1'b0; load = 1'b0;
        segundos_in = 6'd0; minutos_in = 6'd0; horas_in = 6'd0;

        // Basic counting: two reset edges, then free run to edge 27.
        step(2);                                     // edge 2
        ex("reset", 2, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        ex("run_pre1",  11, 0, 0, 0, 0, 0, 0);
        ex("run_tick1", 12, 1, 0, 0, 1, 0, 0);
        ex("run_post1", 13, 1, 0, 0, 0, 0, 0);
        ex("run_pre2",  21, 1, 0, 0, 0, 0, 0);
        ex("run_tick2", 22, 2, 0, 0, 1, 0, 0);
        ex("run_end",   27, 2, 0, 0, 0, 0, 0);
        step(25);                                    // edge 27

        // Full-day rollover from 23:59:59.
        load = 1'b1; segundos_in = 6'd59; minutos_in = 6'd59; horas_in = 6'd23;
        step(1);                                     // edge 28
        load = 1'b0;
        ex("roll_load", 28, 59, 59, 23, 0, 0, 0);
        ex("roll_pre",  37, 59, 59, 23, 0, 0, 0);
        ex("roll_tick", 38, 0, 0, 0, 1, 1, 0);
        ex("roll_post", 39, 0, 0, 0, 0, 0, 0);
        step(16);                                    // edge 44, prescaler = 6

        // Pause for 37 edges starting at prescaler count 6.
        ex("pause_entry", 44, 0, 0, 0, 0, 0, 0);
        pause = 1'b1;
        for (int k = 0; k < 37; k++)
            ex("pause_blink", 45 + k, 0, 0, 0, 0, 0, (k % 10) < 5);
        step(37);                                    // edge 81
        pause = 1'b0;
        ex("unpause_blink", 82, 0, 0, 0, 0, 0, 0);
        ex("unpause_pre",   90, 0, 0, 0, 0, 0, 0);
        ex("unpause_tick",  91, 1, 0, 0, 1, 0, 0);
        step(10);                                    // edge 91

        // Clamped load while paused.
        pause = 1'b1; load = 1'b1;
        segundos_in = 6'd63; minutos_in = 6'd60; horas_in = 6'd30;
        step(1);                                     // edge 92
        load = 1'b0;
        ex("clamp",      92, 59, 59, 23, 0, 0, 1);
        ex("clamp_hold", 93, 59, 59, 23, 0, 0, 1);
        step(1);                                     // edge 93
        pause = 1'b0;
        ex("clamp_roll", 103, 0, 0, 0, 1, 1, 0);
        step(19);                                    // edge 112, prescaler = 9

        // Load coinciding with terminal count.
        load = 1'b1; segundos_in = 6'd56; minutos_in = 6'd34; horas_in = 6'd12;
        step(1);                                     // edge 113
        load = 1'b0;
        ex("tc_load", 113, 56, 34, 12, 0, 0, 0);
        ex("tc_pre",  122, 56, 34, 12, 0, 0, 0);
        ex("tc_tick", 123, 57, 34, 12, 1, 0, 0);
        step(10);                                    // edge 123

        // Reset with a coincident load (and pause) mid-operation.
        load = 1'b1; segundos_in = 6'd7; minutos_in = 6'd6; horas_in = 6'd5;
        step(1);                                     // edge 124
        ex("pre_rst", 124, 7, 6, 5, 0, 0, 0);
        rst = 1'b1; load = 1'b1; pause = 1'b1;
        segundos_in = 6'd30; minutos_in = 6'd30; horas_in = 6'd12;
        step(1);                                     // edge 125
        rst = 1'b0; load = 1'b0; pause = 1'b0;
        ex("rst_mid",  125, 0, 0, 0, 0, 0, 0);
        ex("rst_pre",  134, 0, 0, 0, 0, 0, 0);
        ex("rst_tick", 135, 1, 0, 0, 1, 0, 0);
        step(13);                                    // edge 138

        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d expectations never compared, want 0",
                     sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/contador_relogio.md
CONTADOR_RELOGIO -- requirements
Module: contador_relogio

Interface
REQ-001 Parameter: DIV, default 100_000_000, clk_100MHz cycles per second; legal range 4..2^27, even values only.
REQ-002 Port: clk_100MHz  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: pause  input  1  time-keeping hold, high while the adjust controller is in any adjust mode.
REQ-005 Port: load  input  1  single-cycle strobe; copy segundos_in, minutos_in and horas_in into the time registers.
REQ-006 Port: segundos_in  input  6  seconds value to load, legal range 0..59.
REQ-007 Port: minutos_in  input  6  minutes value to load, legal range 0..59.
REQ-008 Port: horas_in  input  6  hours value to load, legal range 0..23.
REQ-009 Port: segundos  output  6  current seconds, 0..59.
REQ-010 Port: minutos  output  6  current minutes, 0..59.
REQ-011 Port: horas  output  6  current hours, 0..23.
REQ-012 Port: tick_1hz  output  1  one-cycle pulse each time a second elapses.
REQ-013 Port: dia_pulse  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
REQ-014 Port: blink  output  1  display-blink square wave, period DIV cycles, active only while pause is high.

Function
REQ-015 The prescaler SHALL be a register counting 0..DIV-1 and wrapping to 0; tick_1hz SHALL be registered high for the one cycle after the prescaler equals DIV-1.
REQ-016 The first tick_1hz after reset or a release of pause SHALL occur exactly DIV cycles after the prescaler restarts from 0.
REQ-017 While pause=1, the prescaler SHALL be held at 0, tick_1hz SHALL be 0, and segundos, minutos and horas SHALL hold their values.
REQ-018 On a tick, segundos SHALL increment; 59 SHALL wrap to 0 and carry into minutos in the same cycle.
REQ-019 On a minute carry, minutos SHALL increment; 59 SHALL wrap to 0 and carry into horas in the same cycle.
REQ-020 On an hour carry, horas SHALL increment; 23 SHALL wrap to 0 and dia_pulse SHALL be high for that one cycle.
REQ-021 Latency: the time registers SHALL update in the same clock edge that asserts tick_1hz.
REQ-022 When load=1, the time registers SHALL take the input values on that edge, the prescaler SHALL clear to 0, and no tick or carry SHALL be applied in that cycle.
REQ-023 Load priority: load SHALL win over pause and over a coincident prescaler terminal count.
REQ-024 Load clamping: segundos_in or minutos_in values >59 SHALL load as 59, and horas_in values >23 SHALL load as 23.
REQ-025 Counter range: the time registers SHALL never hold out-of-range values.
REQ-026 Pause and load combined: when load and pause are both 1, the load SHALL occur and the hold SHALL resume from the next cycle.
REQ-027 Blink counter: while pause=1, a separate counter SHALL run 0..DIV-1, and blink SHALL be 1 for counts 0..DIV/2-1 and 0 for counts DIV/2..DIV-1.
REQ-028 While pause=0, the blink counter SHALL be held at 0 and blink SHALL be 0.
REQ-029 On every cycle without rst, load, or a tick, all outputs SHALL hold their values.

Reset
REQ-030 When rst=1 at a clock edge, segundos, minutos and horas SHALL be 0.
REQ-031 When rst=1 at a clock edge, tick_1hz, dia_pulse and blink SHALL be 0.
REQ-032 When rst=1 at a clock edge, the prescaler and blink counters SHALL be 0.
REQ-033 rst SHALL override load and pause, and SHALL take effect mid-count with no partial carry.

Verification (DIV=10)
REQ-034 The bench SHALL cover basic counting: rst for 2 cycles, then free-run 25 cycles -> tick_1hz at cycles 10 and 20 after release, and segundos=2.
REQ-035 The bench SHALL cover the full rollover: load 23:59:59, pause=0 -> after 10 cycles, 00:00:00 with dia_pulse and tick_1hz high in the same single cycle.
REQ-036 The bench SHALL cover pause hold: pause=1 for 37 cycles at prescaler count 6 -> no tick and time unchanged; blink waveform 1,1,1,1,1,0,0,0,0,0 repeating; after release, next tick exactly 10 cycles later.
REQ-037 The bench SHALL cover load clamping: load with pause=1 and inputs 63/60/30 -> outputs 59/59/23 on the next cycle.
REQ-038 The bench SHALL cover load at terminal count: load 12:34:56 in the cycle where the prescaler is 9 -> outputs 12:34:56, no tick, next tick 10 cycles later -> 12:34:57.
REQ-039 The bench SHALL cover reset mid-operation: rst asserted together with load at time 05:06:07 -> all outputs 0 on the next cycle, with no load applied.
